// File: rtl/otter_mem_arbiter_pkg.sv
// Shared constants and types for the OTTER main-memory arbiter.
package otter_mem_pkg;

    localparam int unsigned WORDS_PER_LINE   = 8;
    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam int unsigned BEAT_W           = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Cache-side and memory-side signals of the main-memory arbiter.
interface otter_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    import otter_mem_pkg::*;

    localparam int unsigned LINE_W = ADDR_WIDTH - LINE_OFFSET_BITS;

    logic                  i_req;
    logic [LINE_W-1:0]     i_line_addr;
    logic                  d_req;
    logic                  d_we;
    logic [LINE_W-1:0]     d_line_addr;
    logic [31:0]           d_wdata;
    logic                  i_gnt;
    logic                  d_gnt;
    logic [BEAT_W-1:0]     beat_idx;
    logic [31:0]           rd_data;
    logic                  rd_valid;
    logic [BEAT_W-1:0]     rd_beat;
    logic                  i_done;
    logic                  d_done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  busy;

    // Arbiter side
    modport slave (
        input  i_req, i_line_addr, d_req, d_we, d_line_addr, d_wdata, mem_rdata,
        output i_gnt, d_gnt, beat_idx, rd_data, rd_valid, rd_beat,
        output i_done, d_done, mem_addr, mem_we, mem_wdata, busy
    );

    // Cache controllers and memory side
    modport master (
        output i_req, i_line_addr, d_req, d_we, d_line_addr, d_wdata, mem_rdata,
        input  i_gnt, d_gnt, beat_idx, rd_data, rd_valid, rd_beat,
        input  i_done, d_done, mem_addr, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/otter_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; last winner loses the next tie.
module rr_arb2
    import otter_mem_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_req_i,
    input  logic  i_req_d,
    input  logic  i_update,
    output logic  o_valid_c,
    output port_t o_gnt_port_c
);

    port_t r_last_gnt;

    // Combinational pick: lone requester wins, ties go to the port not granted last
    always_comb begin
        o_valid_c    = i_req_i | i_req_d;
        o_gnt_port_c = PORT_I;
        if (i_req_i && i_req_d) begin
            o_gnt_port_c = (r_last_gnt == PORT_I) ? PORT_D : PORT_I;
        end else if (i_req_d) begin
            o_gnt_port_c = PORT_D;
        end
    end

    // Remember the winner at the moment a grant is taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_gnt <= PORT_I;
        end else if (i_update && o_valid_c) begin
            r_last_gnt <= o_gnt_port_c;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares single-port main memory between I-cache fills and D-cache fills/writebacks,
// one 8-beat line burst at a time.
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic               MEM_CLK,
    input  logic               MEM_RST,
    otter_mem_arbiter_if.slave bus
);

    localparam int unsigned       LINE_W    = ADDR_WIDTH - LINE_OFFSET_BITS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    arb_state_t            r_state,    w_state;
    port_t                 r_port,     w_port;
    logic [LINE_W-1:0]     r_line,     w_line;
    logic [BEAT_W-1:0]     r_beat,     w_beat;
    logic                  r_issue,    w_issue;
    logic                  r_i_gnt,    w_i_gnt;
    logic                  r_d_gnt,    w_d_gnt;
    logic                  r_i_done,   w_i_done;
    logic                  r_d_done,   w_d_done;
    logic                  r_mem_we,   w_mem_we;
    logic                  r_busy,     w_busy;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;

    logic [READ_LATENCY-1:0] r_pv;
    logic [BEAT_W-1:0]       r_pb [READ_LATENCY];

    logic  w_arb_valid;
    logic  w_arb_update;
    port_t w_arb_port;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [LINE_W-1:0] line,
                                                        input logic [BEAT_W-1:0] beat);
        return {line, beat, 2'b00};
    endfunction

    rr_arb2 u_rr_arb2 (
        .i_clk        (MEM_CLK),
        .i_rst        (MEM_RST),
        .i_req_i      (bus.i_req),
        .i_req_d      (bus.d_req),
        .i_update     (w_arb_update),
        .o_valid_c    (w_arb_valid),
        .o_gnt_port_c (w_arb_port)
    );

    // Next-state and next-output decode for the burst sequencer
    always_comb begin
        w_state      = r_state;
        w_port       = r_port;
        w_line       = r_line;
        w_beat       = r_beat;
        w_issue      = r_issue;
        w_i_gnt      = r_i_gnt;
        w_d_gnt      = r_d_gnt;
        w_i_done     = 1'b0;
        w_d_done     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_mem_addr;
        w_arb_update = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_arb_update = 1'b1;
                    w_port       = w_arb_port;
                    w_line       = (w_arb_port == PORT_D) ? bus.d_line_addr : bus.i_line_addr;
                    w_beat       = '0;
                    w_mem_addr   = beat_addr(w_line, '0);
                    w_i_gnt      = (w_arb_port == PORT_I);
                    w_d_gnt      = (w_arb_port == PORT_D);
                    if ((w_arb_port == PORT_D) && bus.d_we) begin
                        w_state  = WRITE;
                        w_mem_we = 1'b1;
                    end else begin
                        w_state  = READ;
                        w_issue  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (r_beat == LAST_BEAT) begin
                    w_state  = DONE;
                    w_i_done = (r_port == PORT_I);
                    w_d_done = (r_port == PORT_D);
                end else begin
                    w_beat     = BEAT_W'(r_beat + 1'b1);
                    w_mem_we   = 1'b1;
                    w_mem_addr = beat_addr(r_line, w_beat);
                end
            end
            READ: begin
                // Address beats stop after the last word; stay here until its data drains
                if (r_issue) begin
                    if (r_beat == LAST_BEAT) begin
                        w_issue = 1'b0;
                    end else begin
                        w_beat     = BEAT_W'(r_beat + 1'b1);
                        w_mem_addr = beat_addr(r_line, w_beat);
                    end
                end
                if (r_pv[READ_LATENCY-1] && (r_pb[READ_LATENCY-1] == LAST_BEAT)) begin
                    w_state  = DONE;
                    w_i_done = (r_port == PORT_I);
                    w_d_done = (r_port == PORT_D);
                end
            end
            DONE: begin
                w_state = IDLE;
                w_i_gnt = 1'b0;
                w_d_gnt = 1'b0;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        w_busy = (w_state != IDLE);
    end

    // State and registered outputs; reset aborts any burst immediately
    always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
        if (MEM_RST) begin
            r_state    <= IDLE;
            r_port     <= PORT_I;
            r_line     <= '0;
            r_beat     <= '0;
            r_issue    <= 1'b0;
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_done   <= 1'b0;
            r_d_done   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state;
            r_port     <= w_port;
            r_line     <= w_line;
            r_beat     <= w_beat;
            r_issue    <= w_issue;
            r_i_gnt    <= w_i_gnt;
            r_d_gnt    <= w_d_gnt;
            r_i_done   <= w_i_done;
            r_d_done   <= w_d_done;
            r_mem_we   <= w_mem_we;
            r_busy     <= w_busy;
            r_mem_addr <= w_mem_addr;
        end
    end

    // Read-return tracker: follows each issued read address by the memory latency
    always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
        if (MEM_RST) begin
            r_pv <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pb[k] <= '0;
            end
        end else begin
            r_pv[0] <= (r_state == READ) && r_issue;
            r_pb[0] <= r_beat;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pb[k] <= r_pb[k-1];
            end
        end
    end

    assign bus.i_gnt     = r_i_gnt;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.beat_idx  = r_beat;
    assign bus.rd_valid  = r_pv[READ_LATENCY-1];
    assign bus.rd_beat   = r_pb[READ_LATENCY-1];
    assign bus.i_done    = r_i_done;
    assign bus.d_done    = r_d_done;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.busy      = r_busy;
    // Data paths pass straight through so memory timing is not stretched; gated to 0 when idle
    assign bus.rd_data   = r_pv[READ_LATENCY-1] ? bus.mem_rdata : '0;
    assign bus.mem_wdata = r_mem_we ? bus.d_wdata : '0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for the OTTER main-memory arbiter with a 1-cycle BRAM model.
module tb_otter_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt;

    logic [31:0] mem [16384];

    otter_mem_arbiter_if #(.ADDR_WIDTH(16)) bus ();

    otter_mem_arbiter #(.ADDR_WIDTH(16), .READ_LATENCY(1)) dut (
        .MEM_CLK (clk),
        .MEM_RST (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // D-cache writeback source: word value tracks the beat being written
    assign bus.d_wdata = 32'hA5A5_0000 | 32'(bus.beat_idx);

    // Main-memory BRAM model with registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int j = 0; j < 8; j++) begin
                mem[14'(14'h080 + j)] <= 32'hC0DE_0000 + 32'(j);
                mem[14'(14'h800 + j)] <= 32'hDEAD_0000 + 32'(j);
                mem[14'(14'h100 + j)] <= 32'h5A5A_0000 + 32'(j);
            end
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[15:2]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[15:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Line fill starting in an IDLE cycle; optionally drops req at cycle drop_k
    task automatic do_read(input logic is_d, input logic [10:0] line,
                           input logic [31:0] base, input int drop_k);
        logic [15:0] a0;
        a0 = {line, 5'd0};
        if (is_d) begin
            bus.d_we = 1'b0; bus.d_line_addr = line; bus.d_req = 1'b1;
        end else begin
            bus.i_line_addr = line; bus.i_req = 1'b1;
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                chk("rd_addr", 32'(bus.mem_addr), 32'(a0) + 32'(4 * (k - 1)));
                chk("rd_we", 32'(bus.mem_we), 32'd0);
                chk("rd_beat_idx", 32'(bus.beat_idx), 32'(k - 1));
                chk("rd_gnt", 32'(is_d ? bus.d_gnt : bus.i_gnt), 32'd1);
                chk("rd_other_gnt", 32'(is_d ? bus.i_gnt : bus.d_gnt), 32'd0);
            end
            if (k >= 2 && k <= 9) begin
                chk("rd_valid", 32'(bus.rd_valid), 32'd1);
                chk("rd_beat", 32'(bus.rd_beat), 32'(k - 2));
                chk("rd_data", bus.rd_data, base + 32'(k - 2));
            end else begin
                chk("rd_valid_off", 32'(bus.rd_valid), 32'd0);
            end
            chk("rd_done", 32'(is_d ? bus.d_done : bus.i_done), 32'(k == 10));
            chk("rd_other_done", 32'(is_d ? bus.i_done : bus.d_done), 32'd0);
            if (k == drop_k || k == 10) begin
                if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("rd_gnt_drop", 32'({bus.i_gnt, bus.d_gnt, bus.busy}), 32'd0);
    endtask

    // D writeback starting in an IDLE cycle
    task automatic do_write(input logic [10:0] line);
        logic [15:0] a0;
        a0 = {line, 5'd0};
        bus.d_we = 1'b1; bus.d_line_addr = line; bus.d_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                chk("wr_addr", 32'(bus.mem_addr), 32'(a0) + 32'(4 * (k - 1)));
                chk("wr_we", 32'(bus.mem_we), 32'd1);
                chk("wr_wdata", bus.mem_wdata, 32'hA5A5_0000 | 32'(k - 1));
                chk("wr_gnt", 32'(bus.d_gnt), 32'd1);
            end else begin
                chk("wr_we_off", 32'(bus.mem_we), 32'd0);
            end
            chk("wr_done", 32'(bus.d_done), 32'(k == 9));
            if (k == 9) bus.d_req = 1'b0;
        end
        @(negedge clk);
        chk("wr_gnt_drop", 32'({bus.d_gnt, bus.busy}), 32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 600 ns with both requests pending
        rst = 1'b1; preload = 1'b0;
        bus.i_req = 1'b1; bus.i_line_addr = 11'h001;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_line_addr = 11'h002;
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
        for (int n = 0; n < 6; n++) begin
            repeat (9) @(negedge clk);
            chk("rst_ctl", 32'({bus.busy, bus.i_gnt, bus.d_gnt, bus.mem_we, bus.rd_valid,
                                bus.i_done, bus.d_done, bus.beat_idx, bus.rd_beat}), 32'd0);
            chk("rst_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_data", bus.rd_data | bus.mem_wdata, 32'd0);
        end
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_first_d", 32'({bus.d_gnt, bus.i_gnt}), 32'b10);

        // Both requests held: grants alternate D, I, D, I
        for (int t = 0; t < 4; t++) begin
            cnt = 0;
            while (!(bus.i_gnt || bus.d_gnt) && cnt < 30) begin @(negedge clk); cnt++; end
            chk("rr_grant_timeout", 32'(cnt < 30), 32'd1);
            chk("rr_excl", 32'(bus.i_gnt ^ bus.d_gnt), 32'd1);
            chk("rr_order_d", 32'(bus.d_gnt), 32'(t % 2 == 0));
            cnt = 0;
            while ((bus.i_gnt || bus.d_gnt) && cnt < 30) begin @(negedge clk); cnt++; end
            chk("rr_release_timeout", 32'(cnt < 30), 32'd1);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);

        // Lone I fill of line 0x010
        do_read(1'b0, 11'h010, 32'hC0DE_0000, 0);

        // D writeback to the top line, then fill it back
        do_write(11'h7FF);
        for (int j = 0; j < 8; j++) begin
            chk("wb_mem", mem[14'(14'h3FF8 + j)], 32'hA5A5_0000 | 32'(j));
        end
        do_read(1'b1, 11'h7FF, 32'hA5A5_0000, 0);

        // Reset during writeback beat 3
        bus.d_we = 1'b1; bus.d_line_addr = 11'h100; bus.d_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_pre_beat", 32'(bus.beat_idx), 32'd3);
        chk("abort_pre_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(bus.mem_we), 32'd0);
        chk("abort_busy_gnt", 32'({bus.busy, bus.d_gnt}), 32'd0);
        bus.d_req = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.d_done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done_after", 32'({bus.d_done, bus.busy}), 32'd0);
        for (int j = 0; j < 8; j++) begin
            chk("abort_mem", mem[14'(14'h800 + j)],
                (j < 3) ? (32'hA5A5_0000 | 32'(j)) : (32'hDEAD_0000 + 32'(j)));
        end

        // D fill with req dropped at beat 4: burst still completes, no regrant
        do_read(1'b1, 11'h020, 32'h5A5A_0000, 5);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("drop_no_regrant", 32'({bus.d_gnt, bus.i_gnt, bus.busy}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
